pmem_line_responder: RTL and testbench
======================================

# pmem_line_responder

Synthesizable responder for the physical-memory line interface that the mp3 arbiter drives. It accepts one 256-bit line read or write per request and holds each request for a programmable latency. It completes each request with a single-cycle `pmem_resp`. It replaces the behavioural `physical_memory` model in FPGA builds and serves as a timing-accurate stand-in for integration benches.

## Interface
- `LATENCY`, 10: cycles from the first visible request cycle to `pmem_resp`; legal range ≥1.
- `DEPTH_LINES`, 64: number of 256-bit lines stored; must be a power of two.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pmem_read` in 1: line read request; held until `pmem_resp`.
- `pmem_write` in 1: line write request; held until `pmem_resp`.
- `pmem_address` in 16: byte address; bits [4:0] are ignored.
- `pmem_wdata` in 256: write line; stable while `pmem_write` is high.
- `pmem_resp` out 1: completion pulse, exactly one cycle wide.
- `pmem_rdata` out 256: read line; registered.

## Operation
- Line index = `pmem_address[15:5]` modulo `DEPTH_LINES`; higher index bits alias.
- FSM has three states.
  - IDLE: on `pmem_read|pmem_write`, latch the operation and go to WAIT, or go straight to RESP when the effective latency is 1.
  - WAIT: down-count. At terminal count go to RESP.
  - RESP: assert `pmem_resp`. Perform the access: write commits `pmem_wdata` to the array, or read loads `pmem_rdata`. Return to IDLE unconditionally.
- Address and wdata are sampled in RESP, not at acceptance. The initiator must hold them stable.
- Simultaneous `pmem_read` and `pmem_write`: treat as a write. `pmem_rdata` is unchanged.
- Abort: if both requests are low in any WAIT cycle, return to IDLE. No resp, no array update.
- Operation change mid-WAIT (read→write or write→read): the operation latched at acceptance governs.
- `pmem_rdata` holds its value outside RESP cycles.
- Array contents are zero at time 0 and are not affected by `rst`.

## Timing
- Reset values: `pmem_resp`=0, `pmem_rdata`=256'h0, state=IDLE, counter=0.
- Request first high in cycle t (state IDLE) → `pmem_resp` high in cycle t+L, where L is the effective latency.
- Read data is valid in the same cycle as `pmem_resp`.
- The write is visible to a read accepted in any later cycle.
- Back-to-back: the initiator deasserts in cycle t+L+1. A new request visible in t+L+1 is accepted then.
- A request still high in cycle t+L+1 is taken as a new request and answered again at t+2L+1. Initiators must drop the request after resp.
- `rst` in any state returns to IDLE next cycle with `pmem_resp` low. The in-flight access is discarded and the array is untouched.
- Counter width: `$clog2(LATENCY+8)`.

## Configuration
- Macro: `PMEM_LATENCY_JITTER_EN`.
- Defined:
  - Effective latency = `LATENCY` + `lfsr[2:0]`, i.e. 0–7 extra cycles.
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on `rst`.
  - The LFSR advances once per accepted request.
- Undefined: effective latency = `LATENCY` exactly; no LFSR logic is present.

## Structure
- Package `pmem_types`:
  - `PMEM_LINE_W`=256, `PMEM_ADDR_W`=16, `PMEM_OFFSET_W`=5.
  - `pmem_state_t` enum {IDLE, WAIT, RESP}.
  - LFSR seed and tap constants.
- Sub-module `pmem_line_array`:
  - `DEPTH_LINES`×256 storage.
  - Synchronous write.
  - Registered read port with read enable.
- FSM, counter, and LFSR stay in the top.

## Test plan
- Reset, then read 16'h0040 with LATENCY=10 → `pmem_resp` high in exactly cycle t+10 for one cycle; `pmem_rdata`=0.
- Write 16'h0040 with wdata={8{32'hDEADBEEF}}, then read 16'h0047 → resp at t+10 each time; rdata={8{32'hDEADBEEF}}.
- Aliasing (DEPTH_LINES=64): write 16'h0020 with 256'h1, then read 16'h0820 → rdata=256'h1.
- Abort: write 16'h0060 with 256'hF, drop request in cycle t+4 → no resp within 20 cycles; subsequent read of 16'h0060 returns 0.
- Read and write both high on 16'h0080 with 256'h5 → resp at t+10; rdata unchanged; a later read returns 256'h5.
- `rst` pulsed at t+5 of a write to 16'h00A0 → no resp; line stays 0. Next read resp arrives at full latency. With `PMEM_LATENCY_JITTER_EN`, each latency falls in [10,17] and the sequence repeats after reset.

Source files
------------

// File: rtl/pmem_line_responder_pkg.sv
// Shared widths, FSM encoding and LFSR constants for the pmem line responder.
// The LFSR items are only referenced when PMEM_LATENCY_JITTER_EN is defined.
package pmem_types;

  localparam int PMEM_LINE_W   = 256;
  localparam int PMEM_ADDR_W   = 16;
  localparam int PMEM_OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

  // Fibonacci LFSR, taps 16,14,13,11 map to bits 15,13,12,10.
  localparam int                 PMEM_LFSR_W    = 16;
  localparam logic [PMEM_LFSR_W-1:0] PMEM_LFSR_SEED = 16'hACE1;
  localparam logic [PMEM_LFSR_W-1:0] PMEM_LFSR_TAPS = 16'hB400;

  function automatic logic [PMEM_LFSR_W-1:0] pmem_lfsr_next(input logic [PMEM_LFSR_W-1:0] s);
    return {s[PMEM_LFSR_W-2:0], ^(s & PMEM_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pmem_line_responder_line_array.sv
// Line storage for the responder: synchronous write, registered read with enable.
// Contents are not reset; they rely on power-up zero initialisation of the RAM.
module pmem_line_array
  import pmem_types::*;
#(
  parameter int DEPTH_LINES = 64,
  parameter int IDX_W       = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic                   re,
  input  logic [IDX_W-1:0]       idx,
  input  logic [PMEM_LINE_W-1:0] wdata,
  output logic [PMEM_LINE_W-1:0] rdata
);

  logic [PMEM_LINE_W-1:0] mem [DEPTH_LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/pmem_line_responder.sv
// Fixed-latency 256-bit line responder for the mp3 pmem interface; one request at a time.
// Optional latency jitter (0-7 extra cycles) is enabled by defining PMEM_LATENCY_JITTER_EN.
module pmem_line_responder
  import pmem_types::*;
#(
  parameter int LATENCY     = 10,
  parameter int DEPTH_LINES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pmem_read,
  input  logic                   pmem_write,
  input  logic [PMEM_ADDR_W-1:0] pmem_address,
  input  logic [PMEM_LINE_W-1:0] pmem_wdata,
  output logic                   pmem_resp,
  output logic [PMEM_LINE_W-1:0] pmem_rdata
);

  localparam int CNT_W = $clog2(LATENCY + 8);
  localparam int IDX_W = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;

  pmem_state_t      state;
  pmem_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] eff_lat;
  logic             op_write;
  logic             req;
  logic             accept;
  logic             launch;
  logic             launch_write;
  logic             arr_we;
  logic             arr_re;
  logic [IDX_W-1:0] line_idx;
  logic             unused_addr;

  assign req         = pmem_read | pmem_write;
  assign accept      = (state == IDLE) && req;
  assign line_idx    = pmem_address[PMEM_OFFSET_W +: IDX_W];
  assign unused_addr = ^pmem_address;

`ifdef PMEM_LATENCY_JITTER_EN
  logic [PMEM_LFSR_W-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= PMEM_LFSR_SEED;
    end else if (accept) begin
      lfsr <= pmem_lfsr_next(lfsr);
    end
  end

  assign eff_lat = CNT_W'(LATENCY) + CNT_W'(lfsr[2:0]);
`else
  assign eff_lat = CNT_W'(LATENCY);
`endif

  // The access is launched on the edge that enters RESP so the registered read
  // data lines up with the resp cycle; a drop or reset on that edge cancels it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (eff_lat == CNT_W'(1)) begin
            state_nxt = RESP;
            launch    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = eff_lat - CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(1)) begin
          state_nxt = RESP;
          cnt_nxt   = '0;
          launch    = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_write <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op_write <= pmem_write;
      end
    end
  end

  // With unit latency the launch happens in IDLE, before op_write is latched.
  assign launch_write = (state == IDLE) ? pmem_write : op_write;
  assign arr_we       = launch & launch_write & ~rst;
  assign arr_re       = launch & ~launch_write & ~rst;
  assign pmem_resp    = (state == RESP);

  pmem_line_array #(
    .DEPTH_LINES(DEPTH_LINES),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .re   (arr_re),
    .idx  (line_idx),
    .wdata(pmem_wdata),
    .rdata(pmem_rdata)
  );

  resp_one_cycle: assert property (@(posedge clk) disable iff (rst) pmem_resp |=> !pmem_resp);

endmodule

// File: tb/tb_pmem_line_responder.sv
// Scoreboard bench for pmem_line_responder: directed cases followed by random traffic.
module tb_pmem_line_responder;
  import pmem_types::*;

  localparam int LAT   = 10;
  localparam int DEPTH = 64;
`ifdef PMEM_LATENCY_JITTER_EN
  localparam int JIT = 7;
`else
  localparam int JIT = 0;
`endif

  typedef struct {
    int                     lo;
    int                     hi;
    logic [PMEM_LINE_W-1:0] rdata;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   pmem_read = 1'b0;
  logic                   pmem_write = 1'b0;
  logic [PMEM_ADDR_W-1:0] pmem_address = '0;
  logic [PMEM_LINE_W-1:0] pmem_wdata = '0;
  logic                   pmem_resp;
  logic [PMEM_LINE_W-1:0] pmem_rdata;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pmem_line_responder #(
    .LATENCY    (LAT),
    .DEPTH_LINES(DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_resp   (pmem_resp),
    .pmem_rdata  (pmem_rdata)
  );

  exp_t                   sb[$];
  int                     checks = 0;
  int                     errs = 0;
  int                     resp_seen = 0;
  logic [PMEM_LINE_W-1:0] mem_m [DEPTH];
  logic [PMEM_LINE_W-1:0] rdata_m = '0;
  exp_t                   mon_e;

  task automatic chk(input bit ok, input string nm, input logic [PMEM_LINE_W-1:0] act,
                     input logic [PMEM_LINE_W-1:0] req);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor: every resp pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (pmem_resp) begin
        resp_seen++;
        chk(sb.size() > 0, "unexpected_resp", PMEM_LINE_W'(cyc), '0);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk(cyc >= mon_e.lo && cyc <= mon_e.hi, "resp_cycle",
              PMEM_LINE_W'(cyc), PMEM_LINE_W'(mon_e.lo));
          chk(pmem_rdata == mon_e.rdata, "resp_rdata", pmem_rdata, mon_e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // op: 0 read, 1 write, 2 read+write. drop_at>0 aborts by lowering the request
  // drop_at cycles after it first became visible. Called and returns at posedge+1.
  task automatic issue(input int op, input logic [15:0] addr, input logic [PMEM_LINE_W-1:0] wd,
                       input int drop_at, output int lat);
    int   t;
    int   idx;
    int   n;
    bit   found;
    exp_t e;
    t            = cyc;
    idx          = int'(addr[15:5]) % DEPTH;
    lat          = -1;
    pmem_address = addr;
    pmem_wdata   = wd;
    pmem_read    = (op != 1);
    pmem_write   = (op != 0);
    if (drop_at == 0) begin
      if (op == 0) rdata_m = mem_m[idx];
      else mem_m[idx] = wd;
      e.lo    = t + LAT;
      e.hi    = t + LAT + JIT;
      e.rdata = rdata_m;
      sb.push_back(e);
      found = 1'b0;
      for (int i = 0; i < LAT + JIT + 5 && !found; i++) begin
        @(negedge clk);
        found = pmem_resp;
      end
      chk(found, "resp_timeout", PMEM_LINE_W'(cyc), PMEM_LINE_W'(t + LAT));
      if (found) lat = cyc - t;
      @(posedge clk);
      #1;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
    end else begin
      repeat (drop_at) @(posedge clk);
      #1;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      n = resp_seen;
      repeat (20) @(posedge clk);
      #1;
      chk(resp_seen == n, "abort_no_resp", PMEM_LINE_W'(resp_seen), PMEM_LINE_W'(n));
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    rdata_m = '0;
    sb.delete();
  endtask

  initial begin
    int                     lat;
    int                     n;
    int                     l1 [3];
    int                     l2 [3];
    int                     op;
    int                     drop;
    logic [15:0]            addr;
    logic [PMEM_LINE_W-1:0] wd;

    foreach (mem_m[i]) mem_m[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk(pmem_resp == 1'b0, "reset_resp", PMEM_LINE_W'(pmem_resp), '0);
    chk(pmem_rdata == '0, "reset_rdata", pmem_rdata, '0);

    issue(0, 16'h0040, '0, 0, lat);
    issue(1, 16'h0040, {8{32'hDEADBEEF}}, 0, lat);
    issue(0, 16'h0047, '0, 0, lat);
    chk(pmem_rdata == {8{32'hDEADBEEF}}, "read_after_write", pmem_rdata, {8{32'hDEADBEEF}});

    issue(1, 16'h0020, 256'h1, 0, lat);
    issue(0, 16'h0820, '0, 0, lat);
    chk(pmem_rdata == 256'h1, "alias_read", pmem_rdata, 256'h1);

    issue(1, 16'h0060, 256'hF, 4, lat);
    issue(0, 16'h0060, '0, 0, lat);

    issue(2, 16'h0080, 256'h5, 0, lat);
    issue(0, 16'h0080, '0, 0, lat);

    // Reset mid-write: no resp, line untouched, next read at full latency.
    pmem_address = 16'h00A0;
    pmem_wdata   = {8{32'h12345678}};
    pmem_write   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst        = 1'b1;
    pmem_write = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    rdata_m = '0;
    n       = resp_seen;
    repeat (20) @(posedge clk);
    #1;
    chk(resp_seen == n, "rst_no_resp", PMEM_LINE_W'(resp_seen), PMEM_LINE_W'(n));
    chk(pmem_rdata == '0, "rst_rdata", pmem_rdata, '0);
    issue(0, 16'h00A0, '0, 0, lat);
    chk(lat >= LAT && lat <= LAT + JIT, "rst_read_latency", PMEM_LINE_W'(lat), PMEM_LINE_W'(LAT));

    // Latency sequence must be reproducible from reset.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(0, 16'h0100, '0, 0, lat);
      l1[i] = lat;
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(0, 16'h0100, '0, 0, lat);
      l2[i] = lat;
      chk(l1[i] == l2[i], "latency_repeat", PMEM_LINE_W'(l2[i]), PMEM_LINE_W'(l1[i]));
      chk(l2[i] >= LAT && l2[i] <= LAT + JIT, "latency_range", PMEM_LINE_W'(l2[i]),
          PMEM_LINE_W'(LAT));
    end

    for (int k = 0; k < 60; k++) begin
      op   = int'($urandom_range(0, 2));
      addr = 16'($urandom);
      for (int w = 0; w < 8; w++) wd[w*32 +: 32] = $urandom;
      drop = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, LAT - 1)) : 0;
      issue(op, addr, wd, drop, lat);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk(sb.size() == 0, "sb_drain", PMEM_LINE_W'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
